pmux_pipe: RTL



---
 rtl/pmux_pkg.sv | 19 +
 rtl/pmux_prio_enc.sv | 23 ++
 rtl/pmux_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pmux_pkg.sv
// Shared constants and the priority helper for the pmux_pipe block.
package pmux_pkg;

  localparam int MISS_CNT_W = 16;
  // Widest hit vector prio_first can scan; channel counts above this are unsupported.
  localparam int PRIO_MAX   = 64;

  function automatic int prio_first(input logic [PRIO_MAX-1:0] vec, input int len);
    int res;
    res = len;
    for (int i = PRIO_MAX - 1; i >= 0; i--) begin
      if (i < len && vec[i]) begin
        res = i;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pmux_prio_enc.sv
// Lowest-index priority encoder over an N-bit hit vector; idx_o = N when nothing is set.
module pmux_prio_enc
  import pmux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     vec_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [PRIO_MAX-1:0] vec_ext;

  always_comb begin
    vec_ext = '0;
    vec_ext[N-1:0] = vec_i;
  end

  assign any_o = |vec_i;
  assign idx_o = IDX_W'(prio_first(vec_ext, N));

endmodule

// File: rtl/pmux_pipe.sv
// Two-stage priority-match multiplexer with valid/ready backpressure.
// Define PMUX_PIPE_MISS_CNT_EN to add the saturating miss counter output miss_cnt_o.
module pmux_pipe
  import pmux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int SEL_W  = 32,
  parameter  int DATA_W = 16,
  localparam int IDX_W  = $clog2(NUM_CH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NUM_CH*SEL_W-1:0]      sel_i,
  input  logic [NUM_CH*SEL_W-1:0]      key_i,
  input  logic [(NUM_CH+1)*DATA_W-1:0] data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_W-1:0]            q_o,
  output logic                         hit_o,
  output logic [IDX_W-1:0]             idx_o
`ifdef PMUX_PIPE_MISS_CNT_EN
  ,
  output logic [MISS_CNT_W-1:0]        miss_cnt_o
`endif
);

  logic              s1_adv;
  logic              s2_adv;

  logic              s1_valid_q;
  logic [NUM_CH-1:0] hit_vec_d;
  logic [NUM_CH-1:0] hit_vec_q;
  logic [DATA_W-1:0] data_q [NUM_CH+1];

  logic              out_valid_q;
  logic [DATA_W-1:0] q_d;
  logic [DATA_W-1:0] q_q;
  logic              hit_q;
  logic [IDX_W-1:0]  idx_q;

  logic              enc_any;
  logic [IDX_W-1:0]  enc_idx;

  assign s2_adv     = !out_valid_q || out_ready_i;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready_o = s1_adv;

  // Full-width equality per channel, evaluated on the incoming beat.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cmp
      assign hit_vec_d[gi] = (sel_i[gi*SEL_W +: SEL_W] == key_i[gi*SEL_W +: SEL_W]);
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      hit_vec_q  <= '0;
      for (int i = 0; i <= NUM_CH; i++) begin
        data_q[i] <= '0;
      end
    end else if (s1_adv) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        hit_vec_q <= hit_vec_d;
        for (int i = 0; i <= NUM_CH; i++) begin
          data_q[i] <= data_i[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  pmux_prio_enc #(
    .N (NUM_CH)
  ) u_prio_enc (
    .vec_i (hit_vec_q),
    .any_o (enc_any),
    .idx_o (enc_idx)
  );

  always_comb begin
    q_d = data_q[NUM_CH];
    for (int i = 0; i < NUM_CH; i++) begin
      if (enc_idx == IDX_W'(i)) begin
        q_d = data_q[i];
      end
    end
  end

  // Output fields only move when a real beat is loaded, so bubbles leave them untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      q_q         <= '0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        q_q   <= q_d;
        hit_q <= enc_any;
        idx_q <= enc_idx;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign q_o         = q_q;
  assign hit_o       = hit_q;
  assign idx_o       = idx_q;

`ifdef PMUX_PIPE_MISS_CNT_EN
  logic [MISS_CNT_W-1:0] miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_cnt_q <= '0;
    end else if (out_valid_q && out_ready_i && !hit_q && (miss_cnt_q != '1)) begin
      miss_cnt_q <= miss_cnt_q + MISS_CNT_W'(1);
    end
  end

  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
